mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand and result half width.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  operation request; sampled only in IDLE.
REQ-005 SHALL have port: op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have port: a  input  WIDTH  multiplicand or dividend.
REQ-007 SHALL have port: b  input  WIDTH  multiplier or divisor.
REQ-008 SHALL have port: busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port: done  output  1  one-cycle pulse when hi/lo/div_by_zero update.
REQ-010 SHALL have port: hi  output  WIDTH  product upper half or remainder.
REQ-011 SHALL have port: lo  output  WIDTH  product lower half or quotient.
REQ-012 SHALL have port: div_by_zero  output  1  divide with b==0 flag for last result.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE after WIDTH iterations, DONE->IDLE unconditionally.
REQ-014 SHALL latch a, b, op at the edge accepting start; later input changes SHALL NOT affect the operation.
REQ-015 SHALL ignore start while busy or in DONE (no queueing, no restart).
REQ-016 SHALL, with start accepted at the end of cycle 0, assert busy in cycles 1..WIDTH, assert done only in cycle WIDTH+1 with busy low, and accept a new start in cycle WIDTH+1.
REQ-017 SHALL perform one radix-2 step per RUN cycle: shift-add for multiply, restoring shift-subtract for divide, 6-bit iteration counter for WIDTH=32.
REQ-018 SHALL produce MULTU {hi,lo} = a*b unsigned, 2*WIDTH bits, no truncation.
REQ-019 SHALL produce MULT {hi,lo} = a*b two's complement via magnitude multiply and final sign fix-up.
REQ-020 SHALL produce DIVU lo = a/b, hi = a%b, unsigned.
REQ-021 SHALL produce DIV quotient truncated toward zero; remainder SHALL take the dividend's sign.
REQ-022 SHALL, for DIV most-negative / -1, return lo = most-negative value, hi = 0, no flag.
REQ-023 SHALL, for DIVU/DIV with b==0, set div_by_zero=1, lo = all ones, hi = a, with normal latency.
REQ-024 SHALL clear div_by_zero on any multiply completion and on any divide with b!=0.
REQ-025 SHALL update hi, lo, div_by_zero only at the edge entering DONE and hold them until the next completion.

Reset
REQ-026 SHALL, on rst high at a clock edge, force IDLE with busy=0, done=0, hi=0, lo=0, div_by_zero=0.
REQ-027 SHALL, on rst during RUN or DONE, abort the operation with no done pulse and no result update.
REQ-028 SHALL give rst priority over a simultaneous start; start SHALL NOT be accepted on a reset edge.

Verification
REQ-029 SHALL cover: MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done in cycle 33, hi=0xFFFFFFFE, lo=0x00000001.
REQ-030 SHALL cover: MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1, div_by_zero=0.
REQ-031 SHALL cover: DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=100 b=7 -> lo=14, hi=2.
REQ-032 SHALL cover: DIVU a=10 b=0 -> div_by_zero=1, lo=0xFFFFFFFF, hi=0x0000000A; then MULTU 2*3 -> div_by_zero=0, lo=6.
REQ-033 SHALL cover: DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 SHALL cover: rst in cycle 10 of RUN -> busy=0 next cycle, no done, hi=lo=0; start pulses in busy cycles 5 and 20 of a clean run -> ignored, single done in cycle 33.

Source files
------------

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative radix-2 multiply/divide unit. One shift-add
//               (multiply) or restoring shift-subtract (divide) step per
//               RUN cycle; signed operations run on magnitudes and are
//               sign-corrected when the result is written.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // acc: running product high half / partial remainder
    logic [WIDTH-1:0]   acc_q, acc_d;
    // work: multiplier being shifted out / dividend becoming quotient
    logic [WIDTH-1:0]   work_q, work_d;
    // opnd: multiplicand magnitude / divisor magnitude
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic               dbz_op_q, dbz_op_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dbz_q, dbz_d;

    logic               w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH-1:0]   w_acc_n, w_work_n;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;

    // Operand magnitudes for the signed variants (op[0] selects signed)
    always_comb begin
        w_a_neg = op[0] & a[WIDTH-1];
        w_b_neg = op[0] & b[WIDTH-1];
        w_a_mag = w_a_neg ? (~a + 1'b1) : a;
        w_b_mag = w_b_neg ? (~b + 1'b1) : b;
    end

    // One radix-2 iteration plus the sign-corrected final results
    always_comb begin
        w_sum   = {1'b0, acc_q} + {1'b0, opnd_q};
        w_shift = {acc_q, work_q[WIDTH-1]};
        if (is_div_q) begin
            // Remainder stays below the divisor, so the subtraction fits in WIDTH bits
            if (w_shift >= {1'b0, opnd_q}) begin
                w_acc_n  = w_shift[WIDTH-1:0] - opnd_q;
                w_work_n = {work_q[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_n  = w_shift[WIDTH-1:0];
                w_work_n = {work_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (work_q[0]) begin
                w_acc_n  = w_sum[WIDTH:1];
                w_work_n = {w_sum[0], work_q[WIDTH-1:1]};
            end else begin
                w_acc_n  = {1'b0, acc_q[WIDTH-1:1]};
                w_work_n = {acc_q[0], work_q[WIDTH-1:1]};
            end
        end
        w_prod     = {w_acc_n, w_work_n};
        w_prod_fix = neg_lo_q ? (~w_prod + 1'b1) : w_prod;
        // Most-negative / -1 yields magnitude 2^(W-1), whose negation wraps to itself
        w_quo_fix  = neg_lo_q ? (~w_work_n + 1'b1) : w_work_n;
        w_rem_fix  = neg_hi_q ? (~w_acc_n + 1'b1) : w_acc_n;
    end

    // Next-state, operand capture and result write-back
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        work_d   = work_q;
        opnd_d   = opnd_q;
        a_raw_d  = a_raw_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dbz_op_d = dbz_op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    cnt_d    = '0;
                    acc_d    = '0;
                    a_raw_d  = a;
                    is_div_d = op[1];
                    neg_lo_d = w_a_neg ^ w_b_neg;
                    neg_hi_d = op[1] & w_a_neg;
                    dbz_op_d = op[1] && (b == '0);
                    if (op[1]) begin
                        work_d = w_a_mag;
                        opnd_d = w_b_mag;
                    end else begin
                        work_d = w_b_mag;
                        opnd_d = w_a_mag;
                    end
                end
            end
            S_RUN: begin
                acc_d  = w_acc_n;
                work_d = w_work_n;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = S_DONE;
                    if (!is_div_q) begin
                        hi_d  = w_prod_fix[2*WIDTH-1:WIDTH];
                        lo_d  = w_prod_fix[WIDTH-1:0];
                        dbz_d = 1'b0;
                    end else if (dbz_op_q) begin
                        hi_d  = a_raw_q;
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else begin
                        hi_d  = w_rem_fix;
                        lo_d  = w_quo_fix;
                        dbz_d = 1'b0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over any request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            work_q   <= '0;
            opnd_q   <= '0;
            a_raw_q  <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dbz_op_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            work_q   <= work_d;
            opnd_q   <= opnd_d;
            a_raw_q  <= a_raw_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dbz_op_q <= dbz_op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Self-checking bench for mul_div_unit: directed vector table,
//               randomized operations against an arithmetic reference model,
//               and hand-written reset / ignored-start sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       op_i = 2'd0;
    logic [WIDTH-1:0] a_i = '0;
    logic [WIDTH-1:0] b_i = '0;
    logic             busy, done, div_by_zero;
    logic [WIDTH-1:0] hi, lo;

    int errors = 0;
    int checks = 0;

    mul_div_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op_i), .a(a_i), .b(b_i),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // Reference results straight from the arithmetic definitions
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] rhi, output logic [31:0] rlo, output logic rdbz);
        logic [63:0] p;
        longint      sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        rdbz = 1'b0;
        case (op)
            2'd0: begin
                p = {32'd0, a} * {32'd0, b};
                rhi = p[63:32]; rlo = p[31:0];
            end
            2'd1: begin
                p = 64'(sa * sb);
                rhi = p[63:32]; rlo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    rdbz = 1'b1; rlo = 32'hFFFF_FFFF; rhi = a;
                end else if (op == 2'd2) begin
                    rlo = a / b; rhi = a % b;
                end else begin
                    q = sa / sb; r = sa % sb;
                    p = 64'(q); rlo = p[31:0];
                    p = 64'(r); rhi = p[31:0];
                end
            end
        endcase
    endfunction

    // Issue one operation and track busy/done cycle by cycle (cycle 1 = first after accept)
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit inject, output logic [31:0] rhi, output logic [31:0] rlo,
                          output logic rdbz);
        int bad = 0;
        int done_k = 0;
        int ndone = 0;
        rhi = '0; rlo = '0; rdbz = 1'b0;
        @(negedge clk);
        start = 1'b1; op_i = op; a_i = a; b_i = b;
        @(negedge clk);
        start = 1'b0; op_i = 2'($urandom); a_i = $urandom; b_i = $urandom;
        for (int k = 1; k <= WIDTH + 2; k++) begin
            if (k > 1) @(negedge clk);
            if (busy !== (k <= WIDTH)) bad++;
            if (done === 1'b1) begin
                ndone++;
                if (done_k == 0) begin
                    done_k = k;
                    rhi = hi; rlo = lo; rdbz = div_by_zero;
                end
            end
            start = inject && (k == 5 || k == 20);
        end
        start = 1'b0;
        check("busy_profile_errs", 64'(bad), 64'd0);
        check("done_cycle", 64'(done_k), 64'(WIDTH + 1));
        if (inject) check("done_count", 64'(ndone), 64'd1);
    endtask

    vec_t        tbl[7];
    logic [31:0] g_hi, g_lo, e_hi, e_lo;
    logic        g_dbz, e_dbz;
    int          ndone;

    initial begin
        tbl[0] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        tbl[1] = '{2'd1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        tbl[2] = '{2'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        tbl[3] = '{2'd2, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        tbl[4] = '{2'd2, 32'd10,        32'd0,         32'h0000_000A, 32'hFFFF_FFFF, 1'b1};
        tbl[5] = '{2'd0, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0};
        tbl[6] = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", {busy, done, div_by_zero, hi, lo}, 67'd0);

        // Directed vectors
        for (int i = 0; i < 7; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, g_hi, g_lo, g_dbz);
            check($sformatf("vec%0d_hi", i), g_hi, tbl[i].hi);
            check($sformatf("vec%0d_lo", i), g_lo, tbl[i].lo);
            check($sformatf("vec%0d_dbz", i), g_dbz, tbl[i].dbz);
            check($sformatf("vec%0d_hold", i), {hi, lo, div_by_zero}, {tbl[i].hi, tbl[i].lo, tbl[i].dbz});
        end

        // Start pulses during busy cycles 5 and 20 are ignored
        run_op(2'd1, 32'd1234, 32'hFFFF_FF00, 1'b1, g_hi, g_lo, g_dbz);
        model(2'd1, 32'd1234, 32'hFFFF_FF00, e_hi, e_lo, e_dbz);
        check("ignore_start_result", {g_hi, g_lo}, {e_hi, e_lo});

        // Randomized operations against the model
        for (int i = 0; i < 50; i++) begin
            logic [1:0]  rop;
            logic [31:0] ra, rb;
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = 32'($urandom_range(1, 20));
                default: ;
            endcase
            run_op(rop, ra, rb, 1'b0, g_hi, g_lo, g_dbz);
            model(rop, ra, rb, e_hi, e_lo, e_dbz);
            check($sformatf("rand%0d_op%0d_%h_%h", i, rop, ra, rb), {g_hi, g_lo, 63'(g_dbz)}, {e_hi, e_lo, 63'(e_dbz)});
        end

        // Reset in cycle 10 of RUN aborts with no done and cleared results
        run_op(2'd0, 32'd7, 32'd9, 1'b0, g_hi, g_lo, g_dbz);
        check("pre_abort_lo", g_lo, 32'd63);
        @(negedge clk);
        start = 1'b1; op_i = 2'd2; a_i = 32'd1000; b_i = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_state", {busy, done, div_by_zero, hi, lo}, 67'd0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        check("abort_no_activity", 64'(ndone), 64'd0);

        // Reset has priority over a simultaneous start
        rst = 1'b1; start = 1'b1; op_i = 2'd0; a_i = 32'd3; b_i = 32'd3;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_beats_start", {busy, done}, 2'b00);
        @(negedge clk);
        check("rst_beats_start_2", {busy, done}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
